// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable WIDTH-bit shift register with zero fill and a serial tap at the output end.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_tap
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift_en) begin
            r_q <= MSB_FIRST ? {r_q[WIDTH-2:0], 1'b0} : {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign o_tap = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, one bit per bit_en strobe.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           w_last, w_load, w_shift_en, w_tap, w_in_ready;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (w_last) begin
                        w_in_ready = 1'b1;
                        w_cnt_nxt  = '0;
                        // Shifting out the final bit leaves the register all-zero for IDLE.
                        if (in_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_shift_en  = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_shift_en = 1'b1;
                        w_cnt_nxt  = r_cnt + CW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_shift_en (w_shift_en),
        .i_data     (in_data),
        .o_tap      (w_tap)
    );

    assign in_ready  = w_in_ready;
    assign ser_valid = (r_state == SHIFT);
    assign ser_out   = ser_valid & w_tap;
    assign ser_first = ser_valid & (r_cnt == '0);
    assign ser_last  = ser_valid & w_last;
    assign busy      = ser_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a word/index reference model.
module tb_piso_serializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         bit_en = 1'b0;

    logic rdy_m, out_m, vld_m, fst_m, lst_m, bsy_m;
    logic rdy_l, out_l, vld_l, fst_l, lst_l, bsy_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
        .bit_en(bit_en), .ser_out(out_m), .ser_valid(vld_m), .ser_first(fst_m),
        .ser_last(lst_m), .busy(bsy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
        .bit_en(bit_en), .ser_out(out_l), .ser_valid(vld_l), .ser_first(fst_l),
        .ser_last(lst_l), .busy(bsy_l)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: the word in flight and which frame position is on the line.
    bit           m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int unsigned  m_idx  = 0;

    logic [W-1:0] exp_q_m[$];
    logic [W-1:0] exp_q_l[$];
    logic [W-1:0] cap_acc[2];
    int unsigned  cap_pos[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic capture(input int k, input logic vld, input logic bitv, input logic first,
                           input logic last, input bit msb);
        logic [W-1:0] want;
        if (vld && bit_en) begin
            if (first) begin
                cap_acc[k] = '0;
                cap_pos[k] = 0;
            end
            if (cap_pos[k] < W) cap_acc[k][msb ? (W - 1 - cap_pos[k]) : cap_pos[k]] = bitv;
            cap_pos[k]++;
            if (last) begin
                if (k == 0) begin
                    if (exp_q_m.size() == 0) check("frame_extra_m", 1, 0);
                    else begin want = exp_q_m.pop_front(); check("frame_m", 32'(cap_acc[k]), 32'(want)); end
                end else begin
                    if (exp_q_l.size() == 0) check("frame_extra_l", 1, 0);
                    else begin want = exp_q_l.pop_front(); check("frame_l", 32'(cap_acc[k]), 32'(want)); end
                end
            end
        end
    endtask

    task automatic model_load(input logic [W-1:0] d);
        m_busy = 1'b1;
        m_word = d;
        m_idx  = 0;
        exp_q_m.push_back(d);
        exp_q_l.push_back(d);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic be);
        logic e_rdy, e_out_m, e_out_l;
        in_valid = v;
        in_data  = d;
        bit_en   = be;
        #3;
        e_rdy   = !m_busy || (be && m_idx == W - 1);
        e_out_m = m_busy ? m_word[W - 1 - m_idx] : 1'b0;
        e_out_l = m_busy ? m_word[m_idx] : 1'b0;
        check("ready_m", 32'(rdy_m), 32'(e_rdy));
        check("ready_l", 32'(rdy_l), 32'(e_rdy));
        check("out_m",   32'(out_m), 32'(e_out_m));
        check("out_l",   32'(out_l), 32'(e_out_l));
        check("valid_m", 32'(vld_m), 32'(m_busy));
        check("valid_l", 32'(vld_l), 32'(m_busy));
        check("first_m", 32'(fst_m), 32'(m_busy && m_idx == 0));
        check("first_l", 32'(fst_l), 32'(m_busy && m_idx == 0));
        check("last_m",  32'(lst_m), 32'(m_busy && m_idx == W - 1));
        check("last_l",  32'(lst_l), 32'(m_busy && m_idx == W - 1));
        check("busy_m",  32'(bsy_m), 32'(m_busy));
        check("busy_l",  32'(bsy_l), 32'(m_busy));
        capture(0, vld_m, out_m, fst_m, lst_m, 1'b1);
        capture(1, vld_l, out_l, fst_l, lst_l, 1'b0);
        if (!m_busy) begin
            if (v) model_load(d);
        end else if (be) begin
            if (m_idx == W - 1) begin
                if (v) model_load(d);
                else m_busy = 1'b0;
            end else begin
                m_idx++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_out_m",   32'(out_m), 0);
        check("rst_out_l",   32'(out_l), 0);
        check("rst_valid_m", 32'(vld_m), 0);
        check("rst_valid_l", 32'(vld_l), 0);
        check("rst_first",   32'({fst_m, fst_l}), 0);
        check("rst_last",    32'({lst_m, lst_l}), 0);
        check("rst_busy",    32'({bsy_m, bsy_l}), 0);
        check("rst_ready",   32'({rdy_m, rdy_l}), 32'h3);
    endtask

    task automatic abort_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs();
        m_busy = 1'b0;
        m_idx  = 0;
        exp_q_m.delete();
        exp_q_l.delete();
        cap_pos[0] = 0;
        cap_pos[1] = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        cap_pos[0] = 0;
        cap_pos[1] = 0;
        cap_acc[0] = '0;
        cap_acc[1] = '0;
        #1 reset = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic single frame, bit_en always high
        step(1'b1, 4'b1011, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1);

        // Back-to-back with in_valid held high
        for (int i = 0; i < 4; i++) step(1'b1, 4'hA, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'h5, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1);

        // Slow bit rate: strobe every third cycle
        for (int i = 0; i < 15; i++) step(i == 0, 4'b1100, (i % 3) == 2);

        // Backpressure during an in-flight frame
        step(1'b1, 4'hC, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'h3, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1);

        // Reset mid-frame during bit 2, then a clean frame
        step(1'b1, 4'hF, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        abort_reset();
        step(1'b1, 4'h9, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1);

        // Randomized traffic with varying strobe density
        for (int i = 0; i < 2000; i++) begin
            int unsigned be_pct;
            be_pct = (i / 250) % 2 == 0 ? 100 : 40;
            step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < be_pct);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 4'h0, 1'b1);

        check("frames_left_m", 32'(exp_q_m.size()), 0);
        check("frames_left_l", 32'(exp_q_l.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
